alu_slice_seq: RTL

- Parametrised, multi-cycle successor to the combinational 16-bit ALU.
- Uses the same 6-bit control encoding: zx, nx, zy, ny, f, no.
- Processes operands SLICE bits per clock, carrying between slices, so wide datapaths are built from narrow adder hardware.
- Start/busy/done handshake; registered result; Z/N/C flags for the CPU's conditional-jump logic.

---
 rtl/alu_slice_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_slice_seq.sv
// Multi-cycle ALU using the zx/nx/zy/ny/f/no control encoding.
// Operands are processed SLICE bits per clock, with the carry chained between slices.
module alu_slice_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_r, y_r, shadow;
    logic [5:0]       ctl_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] xs, ys, rs;
    logic [SLICE:0]   sum;
    logic             carry_next;
    logic [WIDTH-1:0] shadow_next;

    // x_r/y_r shift right each slice, so the current slice is always in the low bits.
    always_comb begin
        xs = ctl_r[5] ? '0 : x_r[SLICE-1:0];
        if (ctl_r[4]) xs = ~xs;
        ys = ctl_r[3] ? '0 : y_r[SLICE-1:0];
        if (ctl_r[2]) ys = ~ys;
        sum = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry};
        rs  = ctl_r[1] ? sum[SLICE-1:0] : (xs & ys);
        if (ctl_r[0]) rs = ~rs;
        // The carry is taken before the no inversion and is meaningless for AND.
        carry_next  = ctl_r[1] & sum[SLICE];
        shadow_next = (shadow >> SLICE) | (WIDTH'(rs) << (WIDTH - SLICE));
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too; they are few and it keeps simulation X-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            x_r    <= '0;
            y_r    <= '0;
            ctl_r  <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r   <= x;
                        y_r   <= y;
                        ctl_r <= ctl;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    x_r    <= x_r >> SLICE;
                    y_r    <= y_r >> SLICE;
                    shadow <= shadow_next;
                    carry  <= carry_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(NSLICE - 1)) begin
                        out    <= shadow_next;
                        flag_z <= (shadow_next == '0);
                        flag_n <= shadow_next[WIDTH-1];
                        flag_c <= carry_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
